// File: rtl/reg_index_encoder.sv
// reg_index_encoder: captures a request vector and emits each set bit's index, lowest first.
// Defining ENC_ONEHOT_EN adds out_onehot, the decoded form of out_idx.
module reg_index_encoder #(
    parameter int N_IN  = 32,
    parameter int IDX_W = $clog2(N_IN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
`ifdef ENC_ONEHOT_EN
    output logic [N_IN-1:0]  out_onehot,
`endif
    output logic             busy
);
    typedef enum logic {IDLE, EMIT} state_t;
    state_t st;
    logic [N_IN-1:0] pend;
    logic [IDX_W-1:0] low;
    always_comb begin
        low = '0;
        for (int i = N_IN - 1; i >= 0; i--) if (pend[i]) low = IDX_W'(i);
    end
    assign out_idx  = out_valid ? low : '0;
    assign out_last = out_valid && ((pend & (pend - N_IN'(1))) == '0);
`ifdef ENC_ONEHOT_EN
    assign out_onehot = out_valid ? (N_IN'(1) << out_idx) : '0;
`endif
    // in_ready stays low through reset and rises on the first edge after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            pend      <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (flush) begin
            st        <= IDLE;
            pend      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (st == IDLE) begin
            in_ready <= 1'b1;
            if (in_valid && in_ready && in_vec != '0) begin
                st        <= EMIT;
                pend      <= in_vec;
                in_ready  <= 1'b0;
                out_valid <= 1'b1;
                busy      <= 1'b1;
            end
        end else if (out_ready) begin
            pend[out_idx] <= 1'b0;
            if (out_last) begin
                st        <= IDLE;
                in_ready  <= 1'b1;
                out_valid <= 1'b0;
                busy      <= 1'b0;
            end
        end
    end
endmodule
